// File: rtl/delay_line_ctrl.sv
// Delay-line sequencer: accepts one sample per strobe, fetches the sample written D
// strobes earlier, writes input plus scaled feedback into the circular RAM buffer.
module delay_line_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_sample,
    input  logic [ADDRESS_WIDTH-1:0] delay_len,
    input  logic [7:0]               fb_gain,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_sample,
    output logic                     busy,
    output logic                     overrun
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = DW + 9;

    typedef enum logic [1:0] {IDLE, READ, CALC, OUT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [AW-1:0] dly_q, dly_d;
    logic [DW-1:0] sample_q, sample_d;
    logic [7:0]    gain_q, gain_d;

    logic          ram_wr_en_q, ram_wr_en_d;
    logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_rd_en_q, ram_rd_en_d;
    logic [AW-1:0] ram_rd_addr_q, ram_rd_addr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_sample_q, out_sample_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

    logic signed [DW-1:0] delayed;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] fb_full;
    logic signed [DW:0]   fb;
    logic signed [DW:0]   sum;
    logic [DW-1:0]        sum_sat;

    // Feedback datapath; only meaningful in CALC, when ram_dout holds the delayed tap.
    always_comb begin
        delayed = (fill_cnt_q >= dly_q) ? $signed(ram_dout) : '0;
        product = PW'(delayed) * PW'($signed({1'b0, gain_q}));
        fb_full = product >>> 8;
        fb      = fb_full[DW:0];
        sum     = {sample_q[DW-1], sample_q} + fb;
        if (sum[DW] != sum[DW-1]) begin
            sum_sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sum_sat = sum[DW-1:0];
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        fill_cnt_d    = fill_cnt_q;
        dly_d         = dly_q;
        sample_d      = sample_q;
        gain_d        = gain_q;
        ram_wr_en_d   = 1'b0;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_din_d     = ram_din_q;
        ram_rd_en_d   = 1'b0;
        ram_rd_addr_d = ram_rd_addr_q;
        out_valid_d   = 1'b0;
        out_sample_d  = out_sample_q;
        overrun_d     = overrun_q | (in_valid && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sample_d      = in_sample;
                    gain_d        = fb_gain;
                    dly_d         = (delay_len == '0) ? AW'(1) : delay_len;
                    ram_rd_en_d   = 1'b1;
                    ram_rd_addr_d = wr_ptr_q - dly_d;
                    state_d       = READ;
                end
            end
            READ: begin
                ram_wr_en_d   = 1'b1;
                ram_wr_addr_d = wr_ptr_q;
                state_d       = CALC;
            end
            CALC: begin
                ram_din_d    = sum_sat;
                out_valid_d  = 1'b1;
                out_sample_d = delayed;
                state_d      = OUT;
            end
            OUT: begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fill_cnt_d = (fill_cnt_q == '1) ? fill_cnt_q : fill_cnt_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            fill_cnt_q    <= '0;
            dly_q         <= '0;
            sample_q      <= '0;
            gain_q        <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_din_q     <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            out_valid_q   <= 1'b0;
            out_sample_q  <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_cnt_q    <= fill_cnt_d;
            dly_q         <= dly_d;
            sample_q      <= sample_d;
            gain_q        <= gain_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_din_q     <= ram_din_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            out_valid_q   <= out_valid_d;
            out_sample_q  <= out_sample_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    // Write data depends on ram_dout of the same cycle, so it bypasses the register in CALC.
    assign ram_din     = (state_q == CALC) ? sum_sat : ram_din_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign out_valid   = out_valid_q;
    assign out_sample  = out_sample_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomized and directed bench for delay_line_ctrl against a sample-history model,
// with a 16-entry registered-read RAM holding random stale contents.
module tb_delay_line_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_sample = '0;
    logic [AW-1:0] delay_len = '0;
    logic [7:0]    fb_gain = '0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_dout = '0;
    logic          out_valid;
    logic [DW-1:0] out_sample;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int hist[$];
    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
        .delay_len(delay_len), .fb_gain(fb_gain), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_din(ram_din), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout), .out_valid(out_valid),
        .out_sample(out_sample), .busy(busy), .overrun(overrun)
    );

    always @(posedge clk) begin
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: output is the value written D accepted samples ago (0 if not yet written).
    task automatic model_step(input int x, input int dl, input int g,
                              output int e_out, output int e_din, output int e_rd, output int e_wr);
        int d, n, fill, p, fb;
        d     = (dl == 0) ? 1 : dl;
        n     = hist.size();
        fill  = (n > DEPTH - 1) ? DEPTH - 1 : n;
        e_out = (fill >= d) ? hist[n-d] : 0;
        p     = e_out * g;
        fb    = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        e_din = sat(x + fb);
        e_rd  = (((n - d) % DEPTH) + DEPTH) % DEPTH;
        e_wr  = n % DEPTH;
        hist.push_back(e_din);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, ram_rd_en, 0);
        check({tag, "_wr_en"}, ram_wr_en, 0);
        check({tag, "_rd_addr"}, ram_rd_addr, 0);
        check({tag, "_wr_addr"}, ram_wr_addr, 0);
        check({tag, "_din"}, ram_din, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sample"}, out_sample, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
    endtask

    task automatic send(input int x, input int dl, input int g, output int obs_out, output int obs_din);
        int e_out, e_din, e_rd, e_wr;
        model_step(x, dl, g, e_out, e_din, e_rd, e_wr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = DW'(x);
        delay_len = AW'(dl);
        fb_gain   = 8'(g);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("read_rd_en", ram_rd_en, 1);
        check("read_rd_addr", ram_rd_addr, e_rd);
        check("read_wr_en", ram_wr_en, 0);
        check("read_busy", busy, 1);
        @(posedge clk); #1;
        check("calc_wr_en", ram_wr_en, 1);
        check("calc_rd_en", ram_rd_en, 0);
        check("calc_wr_addr", ram_wr_addr, e_wr);
        check("calc_din", $signed(ram_din), e_din);
        check("calc_out_valid", out_valid, 0);
        obs_din = $signed(ram_din);
        @(posedge clk); #1;
        check("out_valid", out_valid, 1);
        check("out_sample", $signed(out_sample), e_out);
        check("out_wr_en", ram_wr_en, 0);
        check("out_busy", busy, 1);
        obs_out = $signed(out_sample);
        @(posedge clk); #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_hold", $signed(out_sample), e_out);
    endtask

    initial begin
        int o, w, cnt, e_out, e_din, e_rd, e_wr;
        int exp_delay[8]  = '{0, 0, 0, 1, 2, 3, 4, 5};
        int exp_pos[7]    = '{0, 1000, 500, 250, 125, 62, 31};
        int exp_neg[6]    = '{0, -1000, -500, -250, -125, -63};

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-READ aborts the sample and masks stale RAM afterwards.
        for (int i = 0; i < 3; i++) send($urandom_range(1, 30000), 1, 0, o, w);
        @(negedge clk);
        in_valid = 1'b1; in_sample = 16'd999; delay_len = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_rd_en", ram_rd_en, 1);
        rst_n = 1'b0; #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cnt += int'(ram_wr_en) + int'(out_valid);
        end
        check("abort_no_strobes", cnt, 0);
        send(77, 1, 0, o, w);
        check("after_abort_delayed", o, 0);

        // Pure delay.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(i + 1, 3, 0, o, w);
            check("delay_out", o, exp_delay[i]);
            check("delay_din", w, i + 1);
        end

        // Feedback decay, both signs.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send((i == 0) ? 1000 : 0, 1, 128, o, w);
            check("decay_pos", o, exp_pos[i]);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send((i == 0) ? -1000 : 0, 1, 128, o, w);
            check("decay_neg", o, exp_neg[i]);
        end

        // Saturation at both rails.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(32767, 1, 255, o, w);
            check("sat_pos_din", w, 32767);
            check("sat_pos_out", o, (i == 0) ? 0 : 32767);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(-32768, 1, 255, o, w);
            check("sat_neg_din", w, -32768);
            check("sat_neg_out", o, (i == 0) ? 0 : -32768);
        end

        // Overrun: second pulse lands while busy and is dropped.
        do_reset();
        check("overrun_clear", overrun, 0);
        model_step(5, 1, 0, e_out, e_din, e_rd, e_wr);
        @(negedge clk);
        in_valid = 1'b1; in_sample = 16'd5; delay_len = 4'd1; fb_gain = 8'd0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            cnt += int'(out_valid);
        end
        check("overrun_one_out", cnt, 1);
        check("overrun_sample", $signed(out_sample), e_out);
        check("overrun_set", overrun, 1);
        for (int i = 0; i < 3; i++) send(i * 10, 1, 0, o, w);
        check("overrun_sticky", overrun, 1);
        do_reset();
        check("overrun_reset", overrun, 0);

        // Wrap with D = 2^AW - 1, then delay_len = 0 as D = 1.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            send(n + 1, 15, 0, o, w);
            check("wrap_out", o, (n >= 15) ? n + 1 - 15 : 0);
        end
        for (int n = 0; n < 4; n++) begin
            send(500 + n, 0, 0, o, w);
            check("clamp_out", o, (n == 0) ? 40 : 499 + n);
        end

        // Randomized mix of samples, delays and gains.
        for (int n = 0; n < 80; n++) begin
            send($signed(16'($urandom)), $urandom_range(0, 15), $urandom_range(0, 255), o, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
